// File: rtl/operand_sequencer_if.sv
// Operand sequencer bus: switch/button/clear inputs, captured operand pair and handshake.
// master = the sequencer itself, slave = the environment driving switches and consuming operands.
interface operand_sequencer_if #(
  parameter int N = 4
);
  logic [N-1:0] sw;
  logic         load_btn;
  logic         clear;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         op_valid;
  logic         op_ready;
  logic [1:0]   state;
  logic [7:0]   op_count;

  modport master (
    input  sw, load_btn, clear, op_ready,
    output a, b, op_valid, state, op_count
  );

  modport slave (
    output sw, load_btn, clear, op_ready,
    input  a, b, op_valid, state, op_count
  );
endinterface

// File: rtl/operand_sequencer.sv
// Captures two operands from switches on successive button presses and hands the pair downstream.
// Optional button debouncing is enabled by defining OPSEQ_DEBOUNCE_EN (stability count DEB_CYCLES).
module operand_sequencer #(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  operand_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    VALID   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic         op_valid_q, op_valid_d;
  logic [7:0]   op_count_q, op_count_d;
  logic         load_q, load_d;
  logic         load_evt;

`ifdef OPSEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] deb_cnt_q, deb_cnt_d;

  // load_q holds the debounced level; it only flips after DEB_CYCLES disagreeing samples
  always_comb begin
    deb_cnt_d = '0;
    load_d    = load_q;
    load_evt  = 1'b0;
    if (bus.load_btn != load_q) begin
      if (deb_cnt_q == CW'(DEB_CYCLES - 1)) begin
        load_d   = bus.load_btn;
        load_evt = bus.load_btn;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
    end
  end
`else
  logic rel_q;

  // rel_q masks the first edge after reset so a button held through reset is not a press
  always_comb begin
    load_d   = bus.load_btn;
    load_evt = bus.load_btn & ~load_q & rel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q <= 1'b0;
    end else begin
      rel_q <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_count_d = op_count_q;
    if (bus.clear) begin
      state_d = WAIT_A;
      a_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (load_evt) begin
            a_d     = bus.sw;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (load_evt) begin
            b_d     = bus.sw;
            state_d = VALID;
          end
        end
        VALID: begin
          if (op_valid_q && bus.op_ready) begin
            op_count_d = op_count_q + 8'd1;
            state_d    = WAIT_A;
          end
        end
        default: state_d = WAIT_A;
      endcase
    end
    op_valid_d = (state_d == VALID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_valid_q <= 1'b0;
      op_count_q <= 8'd0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_valid_q <= op_valid_d;
      op_count_q <= op_count_d;
      load_q     <= load_d;
    end
  end

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.op_valid = op_valid_q;
  assign bus.state    = state_q;
  assign bus.op_count = op_count_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: directed presses, handshake, clear, wrap and async reset.
// Define OPSEQ_DEBOUNCE_EN to exercise the debounced build.
module tb_operand_sequencer;
  localparam int N   = 4;
  localparam int DEB = 4;
`ifdef OPSEQ_DEBOUNCE_EN
  localparam int PRESS_HI = DEB;
  localparam int PRESS_LO = DEB;
`else
  localparam int PRESS_HI = 1;
  localparam int PRESS_LO = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chkEn  = 1'b0;

  operand_sequencer_if #(.N(N)) bus ();

  operand_sequencer #(.N(N), .DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: phase = number of operands captured in the current sequence (2 = pair on offer)
  logic [N-1:0] mA, mB;
  logic [7:0]   mCount;
  logic [1:0]   mPhase;
  logic         mPrev;
  int           mEdges;
  logic         evt;
`ifdef OPSEQ_DEBOUNCE_EN
  int   hiRun, loRun, nh, nl;
  logic mLvl;

  always_comb begin
    nh  = bus.load_btn ? hiRun + 1 : 0;
    nl  = bus.load_btn ? 0 : loRun + 1;
    evt = !mLvl && (nh == DEB);
  end
`else
  always_comb begin
    evt = bus.load_btn && !mPrev && (mEdges > 0);
  end
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mA     <= '0;
      mB     <= '0;
      mCount <= 8'd0;
      mPhase <= 2'd0;
      mPrev  <= 1'b0;
      mEdges <= 0;
`ifdef OPSEQ_DEBOUNCE_EN
      hiRun  <= 0;
      loRun  <= 0;
      mLvl   <= 1'b0;
`endif
    end else begin
`ifdef OPSEQ_DEBOUNCE_EN
      hiRun <= nh;
      loRun <= nl;
      if (evt) mLvl <= 1'b1;
      else if (mLvl && nl == DEB) mLvl <= 1'b0;
`endif
      mPrev <= bus.load_btn;
      if (mEdges < 1000) mEdges <= mEdges + 1;
      if (bus.clear) begin
        mPhase <= 2'd0;
        mA     <= '0;
        mB     <= '0;
      end else if (mPhase == 2'd0) begin
        if (evt) begin mA <= bus.sw; mPhase <= 2'd1; end
      end else if (mPhase == 2'd1) begin
        if (evt) begin mB <= bus.sw; mPhase <= 2'd2; end
      end else if (bus.op_ready) begin
        mPhase <= 2'd0;
        mCount <= mCount + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("model_a",        32'(bus.a),        32'(mA));
      checkOutput("model_b",        32'(bus.b),        32'(mB));
      checkOutput("model_state",    32'(bus.state),    32'(mPhase));
      checkOutput("model_op_valid", 32'(bus.op_valid), 32'(mPhase == 2'd2));
      checkOutput("model_op_count", 32'(bus.op_count), 32'(mCount));
    end
  end

  task automatic applyStimulus(input logic [N-1:0] s, input logic btn, input logic clr,
                               input logic rdy, input int cycles);
    bus.sw       = s;
    bus.load_btn = btn;
    bus.clear    = clr;
    bus.op_ready = rdy;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic press(input logic [N-1:0] v);
    applyStimulus(v, 1'b1, 1'b0, 1'b0, PRESS_HI);
    applyStimulus(v, 1'b0, 1'b0, 1'b0, PRESS_LO);
  endtask

  initial begin
    bus.sw = '0; bus.load_btn = 1'b0; bus.clear = 1'b0; bus.op_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 chkEn = 1'b1;
    #1;
    checkOutput("reset_state",    32'(bus.state),    32'h0);
    checkOutput("reset_a",        32'(bus.a),        32'h0);
    checkOutput("reset_op_valid", 32'(bus.op_valid), 32'h0);
    checkOutput("reset_op_count", 32'(bus.op_count), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 2);

    // Basic A then B capture
    press(4'hA);
    checkOutput("basic_state_b", 32'(bus.state), 32'h1);
    press(4'h5);
    checkOutput("basic_state", 32'(bus.state),    32'h2);
    checkOutput("basic_a",     32'(bus.a),        32'hA);
    checkOutput("basic_b",     32'(bus.b),        32'h5);
    checkOutput("basic_valid", 32'(bus.op_valid), 32'h1);

    // Downstream stalls five cycles before accepting
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("stall_valid", 32'(bus.op_valid), 32'h1);
    end
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b1, 1);
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("xfer_state", 32'(bus.state),    32'h0);
    checkOutput("xfer_count", 32'(bus.op_count), 32'h1);
    checkOutput("xfer_a",     32'(bus.a),        32'hA);
    checkOutput("xfer_b",     32'(bus.b),        32'h5);

    // Held button yields one capture; presses in VALID are ignored
    applyStimulus(4'h3, 1'b1, 1'b0, 1'b0, 10);
    checkOutput("held_state", 32'(bus.state), 32'h1);
    checkOutput("held_a",     32'(bus.a),     32'h3);
    applyStimulus(4'h3, 1'b0, 1'b0, 1'b0, PRESS_LO);
    press(4'h6);
    press(4'hF);
    checkOutput("lock_state", 32'(bus.state), 32'h2);
    checkOutput("lock_a",     32'(bus.a),     32'h3);
    checkOutput("lock_b",     32'(bus.b),     32'h6);

    // Clear beats a simultaneous transfer, then a simultaneous load
    applyStimulus(4'h0, 1'b0, 1'b1, 1'b1, 1);
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("clear_state", 32'(bus.state),    32'h0);
    checkOutput("clear_a",     32'(bus.a),        32'h0);
    checkOutput("clear_b",     32'(bus.b),        32'h0);
    checkOutput("clear_count", 32'(bus.op_count), 32'h1);
    applyStimulus(4'hC, 1'b1, 1'b1, 1'b0, 1);
    applyStimulus(4'hC, 1'b0, 1'b0, 1'b0, PRESS_LO);
    checkOutput("clear_load_state", 32'(bus.state), 32'h0);
    checkOutput("clear_load_a",     32'(bus.a),     32'h0);

    // 255 more transfers wrap the count to zero
    for (int i = 0; i < 255; i++) begin
      press(N'(i));
      press(N'(i + 3));
      applyStimulus(4'h0, 1'b0, 1'b0, 1'b1, 1);
    end
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("wrap_count", 32'(bus.op_count), 32'h0);

    // Asynchronous reset in the middle of WAIT_B
    press(4'h7);
    checkOutput("pre_reset_state", 32'(bus.state), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_state", 32'(bus.state), 32'h0);
    checkOutput("async_a",     32'(bus.a),     32'h0);
    checkOutput("async_valid", 32'(bus.op_valid), 32'h0);
    @(negedge clk);
    bus.load_btn = 1'b1;
    rst_n = 1'b1;
    applyStimulus(4'h9, 1'b1, 1'b0, 1'b0, 3);
    checkOutput("held_thru_reset_state", 32'(bus.state), 32'h0);
    applyStimulus(4'h9, 1'b0, 1'b0, 1'b0, PRESS_LO);
    press(4'h9);
    checkOutput("restart_state", 32'(bus.state), 32'h1);
    checkOutput("restart_a",     32'(bus.a),     32'h9);

`ifdef OPSEQ_DEBOUNCE_EN
    // Bounce: 3 high, 1 low, then capture on the 4th consecutive high edge
    applyStimulus(4'hE, 1'b1, 1'b0, 1'b0, 3);
    checkOutput("deb_bounce_state", 32'(bus.state), 32'h1);
    applyStimulus(4'hE, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(4'hE, 1'b1, 1'b0, 1'b0, 3);
    checkOutput("deb_third_state", 32'(bus.state), 32'h1);
    applyStimulus(4'hE, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("deb_fourth_state", 32'(bus.state), 32'h2);
    checkOutput("deb_fourth_b",     32'(bus.b),     32'hE);
    applyStimulus(4'hE, 1'b0, 1'b0, 1'b0, PRESS_LO);
`endif

    chkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
